// File: rtl/maze_pkg.sv
// Shared constants for the maze map loader: ROM layout, point-byte fields
// and FSM state encoding.
package maze_pkg;

    localparam int MAZE_ROWS       = 8;
    localparam int MAZE_COLS       = 8;
    localparam int MAZE_ADDR_W     = 4;
    localparam int MAZE_START_ADDR = 8;
    localparam int MAZE_END_ADDR   = 9;

    localparam int ROW_MSB  = 5;
    localparam int ROW_LSB  = 3;
    localparam int COL_MSB  = 2;
    localparam int COL_LSB  = 0;
    localparam int RSVD_MSB = 7;
    localparam int RSVD_LSB = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/maze_map_loader.sv
// Streams the maze map ROM into a cell register array, validates start/end
// points and answers registered single-cell open/closed queries.
module maze_map_loader
    import maze_pkg::*;
#(
    parameter int NROWS      = MAZE_ROWS,
    parameter int ADDR_W     = MAZE_ADDR_W,
    parameter int START_ADDR = MAZE_START_ADDR,
    parameter int END_ADDR   = MAZE_END_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              ready,
    output logic              map_err,
    output logic [2:0]        start_row,
    output logic [2:0]        start_col,
    output logic [2:0]        end_row,
    output logic [2:0]        end_col,
    input  logic [2:0]        q_row,
    input  logic [2:0]        q_col,
    output logic              q_open
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int ROW_W = $clog2(NROWS);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cap_idx;
    logic [7:0]       map [NROWS];
    logic [1:0]       start_rsvd;
    logic [1:0]       end_rsvd;
    logic             load_go;
    logic             start_open;
    logic             end_open;
    logic             same_pt;
    logic             map_bad;
    logic             q_cell;

    assign load_go = load && ((state == ST_IDLE) || (state == ST_DONE));

    // ROM data arrives one edge after the address, so the word captured at
    // stream count n belongs to address n-1.
    assign cap_idx = cnt - CNT_W'(1);

    always_comb begin
        start_open = map[start_row][3'd7 - start_col];
        end_open   = map[end_row][3'd7 - end_col];
        same_pt    = ({start_row, start_col} == {end_row, end_col});
        map_bad    = (start_rsvd != 2'b00) || (end_rsvd != 2'b00) ||
                     !start_open || !end_open || same_pt;
        q_cell     = map[q_row][3'd7 - q_col];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            map_err    <= 1'b0;
            start_row  <= '0;
            start_col  <= '0;
            end_row    <= '0;
            end_col    <= '0;
            start_rsvd <= '0;
            end_rsvd   <= '0;
            q_open     <= 1'b0;
            for (int r = 0; r < NROWS; r++) map[r] <= '0;
        end else begin
            // A reload clears q_open at once so no stale answer escapes.
            q_open <= ready && !load_go && q_cell;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        state    <= ST_STREAM;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        map_err  <= 1'b0;
                        rom_en   <= 1'b1;
                        rom_addr <= '0;
                    end
                end
                ST_STREAM: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rom_en) begin
                        if (rom_addr == ADDR_W'(END_ADDR)) begin
                            rom_en   <= 1'b0;
                            rom_addr <= '0;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                    if (cnt != '0) begin
                        if (cap_idx < CNT_W'(NROWS)) begin
                            map[cap_idx[ROW_W-1:0]] <= rom_data;
                        end else if (cap_idx == CNT_W'(START_ADDR)) begin
                            start_rsvd <= rom_data[RSVD_MSB:RSVD_LSB];
                            start_row  <= rom_data[ROW_MSB:ROW_LSB];
                            start_col  <= rom_data[COL_MSB:COL_LSB];
                        end else if (cap_idx == CNT_W'(END_ADDR)) begin
                            end_rsvd <= rom_data[RSVD_MSB:RSVD_LSB];
                            end_row  <= rom_data[ROW_MSB:ROW_LSB];
                            end_col  <= rom_data[COL_MSB:COL_LSB];
                            state    <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    state   <= ST_DONE;
                    busy    <= 1'b0;
                    ready   <= !map_bad;
                    map_err <= map_bad;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_map_loader.sv
// Self-checking bench for maze_map_loader: synchronous ROM model plus a
// cell/validity reference model computed directly from the ROM image.
module tb_maze_map_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       busy, ready, map_err;
    logic [2:0] start_row, start_col, end_row, end_col;
    logic [2:0] q_row = 3'd0;
    logic [2:0] q_col = 3'd0;
    logic       q_open;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom_img [10];

    always #5 clk = ~clk;

    maze_map_loader dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .ready(ready), .map_err(map_err),
        .start_row(start_row), .start_col(start_col),
        .end_row(end_row), .end_col(end_col),
        .q_row(q_row), .q_col(q_col), .q_open(q_open)
    );

    // Synchronous ROM: data for an address appears one edge after it is presented.
    always @(posedge clk) begin
        if (rom_en) rom_data <= (int'(rom_addr) < 10) ? rom_img[int'(rom_addr)] : 8'hEE;
    end

    // ---------------- reference model ----------------
    function automatic bit m_cell(input int r, input int c);
        return ((int'(rom_img[r]) >> (7 - c)) & 1) == 1;
    endfunction

    function automatic bit m_err();
        int s, e;
        s = int'(rom_img[8]);
        e = int'(rom_img[9]);
        if (s >= 64 || e >= 64) return 1'b1;
        if (!m_cell(s / 8, s % 8)) return 1'b1;
        if (!m_cell(e / 8, e % 8)) return 1'b1;
        return s == e;
    endfunction

    function automatic logic [11:0] m_pts();
        int s, e;
        s = int'(rom_img[8]) % 64;
        e = int'(rom_img[9]) % 64;
        return {3'(s / 8), 3'(s % 8), 3'(e / 8), 3'(e % 8)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_img(input logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, s, e);
        rom_img[0] = r0; rom_img[1] = r1; rom_img[2] = r2; rom_img[3] = r3;
        rom_img[4] = r4; rom_img[5] = r5; rom_img[6] = r6; rom_img[7] = r7;
        rom_img[8] = s;  rom_img[9] = e;
    endtask

    int   en_cnt, done_k;
    bit   en_bad, addr_bad, q_bad, early_ready;
    logic busy_done;

    // Drives one load and records what the interface did over 15 edges.
    task automatic do_load(input int ra, input int rb);
        en_cnt = 0; done_k = -1; en_bad = 0; addr_bad = 0; q_bad = 0;
        early_ready = 0; busy_done = 1'bx;
        load = 1'b1;
        tick();
        load = 1'b0;
        if (ready !== 1'b0 || map_err !== 1'b0) early_ready = 1;
        for (int k = 0; k < 15; k++) begin
            if (rom_en !== ((k < 10) ? 1'b1 : 1'b0)) en_bad = 1;
            if (rom_en === 1'b1) begin
                if (rom_addr !== 4'(k)) addr_bad = 1;
                en_cnt++;
            end
            if (ready !== 1'b1 && q_open !== 1'b0) q_bad = 1;
            if (done_k < 0 && (ready === 1'b1 || map_err === 1'b1)) begin
                done_k = k;
                busy_done = busy;
            end
            load = ((k + 1) == ra || (k + 1) == rb) ? 1'b1 : 1'b0;
            tick();
        end
        load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({rom_en, rom_addr, busy, ready, map_err, q_open} !== 9'd0 ||
            {start_row, start_col, end_row, end_col} !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: en=%b addr=%0d busy=%b ready=%b err=%b q=%b pts=%h required all 0",
                     rom_en, rom_addr, busy, ready, map_err, q_open,
                     {start_row, start_col, end_row, end_col});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({rom_en, busy, ready, map_err, q_open} !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset: en=%b busy=%b ready=%b err=%b q=%b required 0",
                     rom_en, busy, ready, map_err, q_open);
        end
    endtask

    task automatic test_basic_load();
        set_img(8'hFF, 8'h81, 8'hEF, 8'h64, 8'hF7, 8'h11, 8'hF7, 8'h8C, 8'h08, 8'h3C);
        do_load(-1, -1);
        checks++;
        if (done_k != 12 || early_ready) begin
            errors++;
            $display("FAIL basic_latency: done at %0d (early=%0d) required 12", done_k, early_ready);
        end
        checks++;
        if ({ready, map_err, busy_done} !== 3'b100) begin
            errors++;
            $display("FAIL basic_flags: ready/err/busy=%b%b%b required 100", ready, map_err, busy_done);
        end
        checks++;
        if ({start_row, start_col, end_row, end_col} !== {3'd1, 3'd0, 3'd7, 3'd4}) begin
            errors++;
            $display("FAIL basic_points: start=(%0d,%0d) end=(%0d,%0d) required (1,0) (7,4)",
                     start_row, start_col, end_row, end_col);
        end
        checks++;
        if (en_cnt != 10 || en_bad || addr_bad) begin
            errors++;
            $display("FAIL basic_rom_seq: en cycles=%0d en_bad=%0d addr_bad=%0d required 10,0,0",
                     en_cnt, en_bad, addr_bad);
        end
    endtask

    task automatic test_queries();
        int qr [5] = '{0, 3, 3, 5, 7};
        int qc [5] = '{0, 0, 1, 3, 7};
        bit exp [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            q_row = 3'(qr[i]);
            q_col = 3'(qc[i]);
            tick();
            checks++;
            if (q_open !== exp[i]) begin
                errors++;
                $display("FAIL query_%0d_%0d: q_open=%b required %b", qr[i], qc[i], q_open, exp[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] sb [3] = '{8'h48, 8'h0B, 8'h08};
        logic [7:0] eb [3] = '{8'h3C, 8'h3C, 8'h08};
        for (int i = 0; i < 3; i++) begin
            set_img(8'hFF, 8'h81, 8'hEF, 8'h64, 8'hF7, 8'h11, 8'hF7, 8'h8C, sb[i], eb[i]);
            do_load(-1, -1);
            checks++;
            if ({ready, map_err} !== 2'b01 || done_k != 12) begin
                errors++;
                $display("FAIL invalid_%0d: ready=%b err=%b done=%0d required ready=0 err=1 at 12",
                         i, ready, map_err, done_k);
            end
            q_row = 3'd0; q_col = 3'd0;
            tick();
            checks++;
            if (q_open !== 1'b0) begin
                errors++;
                $display("FAIL invalid_%0d_query: q_open=%b required 0", i, q_open);
            end
        end
    endtask

    task automatic test_random_maps();
        int sr, sc, er, ec, mode, r, c;
        bit exp_err, exp_q;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 8; k++) rom_img[k] = 8'($urandom);
            sr = $urandom_range(0, 7); sc = $urandom_range(0, 7);
            er = $urandom_range(0, 7); ec = $urandom_range(0, 7);
            if (sr == er && sc == ec) ec = (ec + 1) % 8;
            rom_img[sr] = rom_img[sr] | (8'h80 >> sc);
            rom_img[er] = rom_img[er] | (8'h80 >> ec);
            rom_img[8] = 8'(sr * 8 + sc);
            rom_img[9] = 8'(er * 8 + ec);
            mode = $urandom_range(0, 4);
            if (mode == 1) rom_img[8] = rom_img[8] | 8'h80;
            if (mode == 2) rom_img[9] = rom_img[9] | 8'h40;
            if (mode == 3) rom_img[sr] = rom_img[sr] & ~(8'h80 >> sc);
            if (mode == 4) rom_img[9] = rom_img[8];
            exp_err = m_err();
            do_load(-1, -1);
            checks++;
            if ({ready, map_err} !== {~exp_err, exp_err} || done_k != 12 ||
                en_cnt != 10 || addr_bad) begin
                errors++;
                $display("FAIL rand_%0d_load: ready=%b err=%b done=%0d en=%0d required ready=%b err=%b 12 10",
                         it, ready, map_err, done_k, en_cnt, ~exp_err, exp_err);
            end
            checks++;
            if ({start_row, start_col, end_row, end_col} !== m_pts()) begin
                errors++;
                $display("FAIL rand_%0d_points: got %h required %h", it,
                         {start_row, start_col, end_row, end_col}, m_pts());
            end
            for (int j = 0; j < 6; j++) begin
                r = $urandom_range(0, 7); c = $urandom_range(0, 7);
                q_row = 3'(r); q_col = 3'(c);
                exp_q = !exp_err && m_cell(r, c);
                tick();
                checks++;
                if (q_open !== exp_q) begin
                    errors++;
                    $display("FAIL rand_%0d_query_%0d_%0d: q_open=%b required %b", it, r, c, q_open, exp_q);
                end
            end
        end
    endtask

    task automatic test_overlap();
        set_img(8'hFF, 8'h81, 8'hEF, 8'h64, 8'hF7, 8'h11, 8'hF7, 8'h8C, 8'h08, 8'h3C);
        do_load(3, 7);
        checks++;
        if (done_k != 12 || en_cnt != 10 || en_bad || addr_bad || ready !== 1'b1) begin
            errors++;
            $display("FAIL overlap: done=%0d en=%0d en_bad=%0d addr_bad=%0d ready=%b required 12 10 0 0 1",
                     done_k, en_cnt, en_bad, addr_bad, ready);
        end
    endtask

    task automatic test_reset_midload();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, rom_addr, busy, ready, map_err, q_open} !== 9'd0 ||
            {start_row, start_col, end_row, end_col} !== 12'd0) begin
            errors++;
            $display("FAIL reset_midload: en=%b addr=%0d busy=%b ready=%b err=%b q=%b required all 0",
                     rom_en, rom_addr, busy, ready, map_err, q_open);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_load(-1, -1);
        checks++;
        if (done_k != 12 || ready !== 1'b1 || en_cnt != 10 ||
            {start_row, start_col, end_row, end_col} !== m_pts()) begin
            errors++;
            $display("FAIL reload_after_reset: done=%0d ready=%b en=%0d required 12 1 10", done_k, ready, en_cnt);
        end
    endtask

    task automatic test_reload();
        q_row = 3'd0; q_col = 3'd0;
        tick();
        set_img(8'h3C, 8'h7E, 8'h00, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h81, 8'h0A, 8'h38);
        do_load(-1, -1);
        checks++;
        if (early_ready || q_bad) begin
            errors++;
            $display("FAIL reload_drop: early_ready=%0d q_bad=%0d required 0 0", early_ready, q_bad);
        end
        checks++;
        if (done_k != 12 || {ready, map_err} !== 2'b10 ||
            {start_row, start_col, end_row, end_col} !== {3'd1, 3'd2, 3'd7, 3'd0}) begin
            errors++;
            $display("FAIL reload_result: done=%0d ready=%b err=%b pts=%h required 12 1 0 %h",
                     done_k, ready, map_err, {start_row, start_col, end_row, end_col},
                     {3'd1, 3'd2, 3'd7, 3'd0});
        end
        for (int i = 0; i < 8; i++) begin
            q_row = 3'(i); q_col = 3'(7 - i);
            tick();
            checks++;
            if (q_open !== m_cell(i, 7 - i)) begin
                errors++;
                $display("FAIL reload_query_%0d: q_open=%b required %b", i, q_open, m_cell(i, 7 - i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_queries();
        test_invalid();
        test_random_maps();
        test_overlap();
        test_reset_midload();
        test_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_map_loader.md
Name: maze_map_loader

Overview:
- Reader for the maze map ROM interface (8x8 map: rows at addresses 0-7, start point at 8, end point at 9).
- On a load request it streams all 10 ROM words through the synchronous ROM port and captures the 64 cell bits plus the start/end coordinates into registers.
- It then validates the map and serves single-cell open/closed queries to the game/movement logic.
- Sits between a maprom instance and the player-movement and display blocks.

Parameters:
- NROWS, 8, number of map rows (ROM addresses 0..NROWS-1).
- ADDR_W, 4, ROM address width.
- START_ADDR, 8, ROM address of the start-point byte.
- END_ADDR, 9, ROM address of the end-point byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle load request.
- rom_en  out  1  ROM read enable (registered).
- rom_addr  out  ADDR_W  ROM address (registered).
- rom_data  in  8  ROM read data; valid one cycle after the addr/en it answers.
- busy  out  1  load in progress.
- ready  out  1  map loaded and valid.
- map_err  out  1  map loaded but invalid.
- start_row, start_col, end_row, end_col  out  3 each  captured coordinates.
- q_row, q_col  in  3 each  cell query coordinates.
- q_open  out  1  1 = queried cell open; registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs are 0.
  - Map register (64 bits) and all coordinates are 0.
  - FSM is in IDLE.
- Bit mapping:
  - Row byte r, bit (7-c) holds cell (r,c), so MSB = column 0.
  - A 1 means the cell is open.
  - Point byte: [7:6] reserved (must be 0), [5:3] row, [2:0] col.
- FSM states: IDLE, STREAM, CHECK, DONE.
  - IDLE/DONE: load=1 at edge E0 moves to STREAM. At E0: busy<=1, ready<=0, map_err<=0, rom_en<=1, rom_addr<=0.
  - STREAM: rom_addr increments by 1 each edge. After addr 9 has been presented, rom_en<=0 and rom_addr<=0.
  - The ROM registers addr k at E(k+1); the loader captures rom_data for addr k at E(k+2). Captures therefore occur at E2..E11.
  - After the E11 capture, go to CHECK.
  - CHECK (one cycle), then DONE at E12: busy<=0, and exactly one of ready/map_err <=1.
  - map_err is set if any of these holds: start or end reserved bits nonzero; start cell closed; end cell closed; start == end. Otherwise ready is set.
- Latency:
  - load to ready/map_err = 12 cycles.
  - rom_en is high for exactly 10 consecutive cycles per load.
- load while busy is ignored; no restart and no queuing.
- load in DONE is a reload:
  - ready/map_err drop at E0.
  - Old map contents stay readable until overwritten.
  - q_open is forced to 0 while ready=0.
- Queries: q_open <= ready & map[q_row][q_col], one-cycle latency from q_row/q_col.
- Captured start/end coordinates update at their capture edge and hold until the next load or reset.
- Reset mid-STREAM: immediate return to the reset state, rom_en drops asynchronously, and no partial ready.
- ROM addresses 10-15 are never issued.

Decomposition:
- Package maze_pkg holds:
  - Constants MAZE_ROWS=8, MAZE_COLS=8, MAZE_ADDR_W=4, MAZE_START_ADDR=8, MAZE_END_ADDR=9.
  - Point-byte field positions: ROW_MSB=5, ROW_LSB=3, COL_MSB=2, COL_LSB=0, RSVD bits [7:6].
  - FSM state encoding.
- No sub-module in RTL; the single FSM plus map register array fits one module.
- The bench instantiates the existing synchronous ROM model as the stimulus source.

Test Plan:
- Basic load: reset, then load pulse with ROM rows FF,81,EF,64,F7,11,F7,8C, start 08, end 3C:
  - ready=1 exactly 12 cycles after load, map_err=0, busy=0.
  - start=(1,0), end=(7,4).
  - rom_en high 10 cycles with addr 0..9.
- Queries after basic load:
  - (0,0)->1, (3,0)->0, (3,1)->1, (5,3)->1, (7,7)->0.
  - Each result appears one cycle after the query is applied.
- Invalid maps:
  - start byte 48 (reserved bit 6 set) -> map_err=1, ready=0.
  - start byte 0B (cell (1,3) closed) -> map_err=1.
  - start = end = 08 -> map_err=1.
- Overlap: load re-pulsed at cycles 3 and 7 of a load -> ignored; still exactly 10 rom_en cycles and ready at cycle 12 after the first load.
- Reset mid-load: rst_n low at cycle 5 -> all outputs 0 immediately. A fresh load then completes normally in 12 cycles.
- Reload: while ready, load a different ROM image -> ready drops at E0, q_open reads 0 during reload, and the new start/end and cells are correct after 12 cycles.
